decode: RTL and testbench

Second pipeline stage of the MIPS core, directly downstream of instruction fetch. Consumes the fetched `pc`/`ir` pair, reads the 32-entry register file, decodes control, and resolves jumps and branches combinationally back to fetch via `jump`/`target`. All operands and control for execute are registered here. The branch delay slot needs no squash logic: the instruction already in flight executes.

---
 rtl/decode.sv | 187 ++++++++++++++++++
 tb/tb_decode.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// MIPS decode stage: register file, control decode, branch/jump resolve.
// Registers operands and control for execute; redirects fetch combinationally.
module decode #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  jump,
  output logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs,
  output logic [DATA_WIDTH-1:0] ex_rt,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_shamt,
  output logic [4:0]            ex_dest,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI,
    ALU_LINK
  } alu_op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs;
    logic [DATA_WIDTH-1:0] rt;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            shamt;
    logic [4:0]            dest;
    logic [3:0]            alu_op;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  illegal;
  } id_ex_t;

  logic [DATA_WIDTH-1:0] rf_q [32];
  logic [4:0]            rs_idx, rt_idx, rd_idx;
  logic [5:0]            opc, fn;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, sext, zext;
  id_ex_t                ex_d, ex_q;

  assign opc    = ir[31:26];
  assign fn     = ir[5:0];
  assign rs_idx = ir[25:21];
  assign rt_idx = ir[20:16];
  assign rd_idx = ir[15:11];
  assign sext   = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
  assign zext   = {{(DATA_WIDTH-16){1'b0}}, ir[15:0]};

  assign rs_val = (rs_idx == 5'd0) ? '0 :
                  (wb_en && wb_addr == rs_idx) ? wb_data : rf_q[rs_idx];
  assign rt_val = (rt_idx == 5'd0) ? '0 :
                  (wb_en && wb_addr == rt_idx) ? wb_data : rf_q[rt_idx];

  // Register file write port; r0 never stored, contents survive reset
  always_ff @(posedge clk) begin
    if (wb_en && wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
  end

  // Control decode plus same-cycle jump/branch resolution
  always_comb begin
    alu_op_e alu;
    logic [4:0] dest;
    logic wr, src, mr, mw, ill, use_z;
    alu    = ALU_ADD;
    dest   = 5'd0;
    wr     = 1'b0;
    src    = 1'b0;
    mr     = 1'b0;
    mw     = 1'b0;
    ill    = 1'b0;
    use_z  = 1'b0;
    jump   = 1'b0;
    target = pc + sext;
    unique case (opc)
      6'h00: begin
        dest = rd_idx;
        wr   = 1'b1;
        unique case (fn)
          6'h20, 6'h21: alu = ALU_ADD;
          6'h22, 6'h23: alu = ALU_SUB;
          6'h24: alu = ALU_AND;
          6'h25: alu = ALU_OR;
          6'h26: alu = ALU_XOR;
          6'h27: alu = ALU_NOR;
          6'h2A: alu = ALU_SLT;
          6'h2B: alu = ALU_SLTU;
          6'h00: alu = ALU_SLL;
          6'h02: alu = ALU_SRL;
          6'h03: alu = ALU_SRA;
          6'h08: begin
            jump   = 1'b1;
            target = rs_val;
            dest   = 5'd0;
            wr     = 1'b0;
          end
          6'h09: begin
            jump   = 1'b1;
            target = rs_val;
            alu    = ALU_LINK;
          end
          default: ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin alu = ALU_ADD;  src = 1'b1; dest = rt_idx; wr = 1'b1; end
      6'h0A: begin alu = ALU_SLT;  src = 1'b1; dest = rt_idx; wr = 1'b1; end
      6'h0B: begin alu = ALU_SLTU; src = 1'b1; dest = rt_idx; wr = 1'b1; end
      6'h0C: begin alu = ALU_AND;  src = 1'b1; dest = rt_idx; wr = 1'b1; use_z = 1'b1; end
      6'h0D: begin alu = ALU_OR;   src = 1'b1; dest = rt_idx; wr = 1'b1; use_z = 1'b1; end
      6'h0E: begin alu = ALU_XOR;  src = 1'b1; dest = rt_idx; wr = 1'b1; use_z = 1'b1; end
      6'h0F: begin alu = ALU_LUI;  src = 1'b1; dest = rt_idx; wr = 1'b1; use_z = 1'b1; end
      6'h23: begin src = 1'b1; mr = 1'b1; dest = rt_idx; wr = 1'b1; end
      6'h2B: begin src = 1'b1; mw = 1'b1; end
      6'h04: jump = (rs_val == rt_val);
      6'h05: jump = (rs_val != rt_val);
      6'h02: begin
        jump   = 1'b1;
        target = {pc[DATA_WIDTH-1:26], ir[25:0]};
      end
      6'h03: begin
        jump   = 1'b1;
        target = {pc[DATA_WIDTH-1:26], ir[25:0]};
        alu    = ALU_LINK;
        dest   = 5'd31;
        wr     = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      alu  = ALU_ADD;
      dest = 5'd0;
      wr   = 1'b0;
      src  = 1'b0;
      mr   = 1'b0;
      mw   = 1'b0;
      jump = 1'b0;
    end
    ex_d           = '0;
    ex_d.pc        = pc;
    ex_d.rs        = rs_val;
    ex_d.rt        = rt_val;
    ex_d.imm       = use_z ? zext : sext;
    ex_d.shamt     = ir[10:6];
    ex_d.dest      = dest;
    ex_d.alu_op    = alu;
    ex_d.alu_src   = src;
    ex_d.reg_write = wr && (dest != 5'd0);
    ex_d.mem_read  = mr;
    ex_d.mem_write = mw;
    ex_d.illegal   = ill;
  end

  // Execute bundle; reset looks like a NOP downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign ex_pc        = ex_q.pc;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_imm       = ex_q.imm;
  assign ex_shamt     = ex_q.shamt;
  assign ex_dest      = ex_q.dest;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected execute bundles are queued at
// issue time and a monitor compares them one cycle later.
module tb_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [4:0]  dest;
    logic [3:0]  op;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] ir = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        jump;
  logic [31:0] target;
  logic [31:0] ex_pc, ex_rs, ex_rt, ex_imm;
  logic [4:0]  ex_shamt, ex_dest;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  int n_vec = 0;
  int n_bad = 0;
  exp_t  q[$];
  string nq[$];

  decode #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ir(ir),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump(jump), .target(target),
    .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] p, rs, rt, imm,
    input logic [4:0] sh, d,
    input logic [3:0] op,
    input logic src, rw, mr, mw, ill);
    exp_t e;
    e = '{pc: p, rs: rs, rt: rt, imm: imm, sh: sh, dest: d, op: op,
          src: src, rw: rw, mr: mr, mw: mw, ill: ill};
    return e;
  endfunction

  function automatic exp_t act();
    exp_t a;
    a = '{pc: ex_pc, rs: ex_rs, rt: ex_rt, imm: ex_imm, sh: ex_shamt,
          dest: ex_dest, op: ex_alu_op, src: ex_alu_src,
          rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write,
          ill: ex_illegal};
    return a;
  endfunction

  task automatic drive(input string nm, input logic [31:0] p, i,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input exp_t e);
    @(negedge clk);
    pc = p; ir = i; wb_en = we; wb_addr = wa; wb_data = wd;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic chk_j(input string nm, input logic ej,
                       input logic [31:0] et, input logic ct);
    #1;
    n_vec++;
    if (jump !== ej || (ct && target !== et)) begin
      n_bad++;
      $display("FAIL %s: got jump=%0b target=%h, want jump=%0b target=%h",
               nm, jump, target, ej, et);
    end
  endtask

  // Scoreboard monitor: one queued bundle per clock edge
  always @(posedge clk) begin
    exp_t  e, a;
    string nm;
    #1;
    if (q.size() > 0) begin
      e  = q.pop_front();
      nm = nq.pop_front();
      a  = act();
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, a, e);
      end
    end
  end

  initial begin
    exp_t z;
    z = '0;
    for (int k = 0; k < 3; k++)
      drive("reset", $urandom, $urandom, 1'b0, 5'd0, 32'h0, z);
    @(posedge clk);
    #2;
    rst = 1'b1;

    drive("nop_wr_r1", 32'h1, 32'h0, 1'b1, 5'd1, 32'd7,
          mk(32'h1, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, 0, 0));
    chk_j("nop_jump", 1'b0, 32'h0, 1'b0);
    drive("nop_wr_r2", 32'h2, 32'h0, 1'b1, 5'd2, 32'd7,
          mk(32'h2, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, 0, 0));
    drive("nop_wr_r4", 32'h3, 32'h0, 1'b1, 5'd4, 32'h55,
          mk(32'h3, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, 0, 0));
    drive("bypass_add", 32'h4, 32'h00A01820, 1'b1, 5'd5, 32'h1234,
          mk(32'h4, 32'h1234, 0, 32'h1820, 0, 3, 4'd0, 0, 1, 0, 0, 0));
    drive("beq", 32'h10, 32'h1022FFFC, 1'b0, 5'd0, 32'h0,
          mk(32'h10, 7, 7, 32'hFFFFFFFC, 5'h1F, 0, 4'd0, 0, 0, 0, 0, 0));
    chk_j("beq_taken", 1'b1, 32'h0000000C, 1'b1);
    drive("bne", 32'h10, 32'h1422FFFC, 1'b0, 5'd0, 32'h0,
          mk(32'h10, 7, 7, 32'hFFFFFFFC, 5'h1F, 0, 4'd0, 0, 0, 0, 0, 0));
    chk_j("bne_not_taken", 1'b0, 32'h0, 1'b0);
    drive("jal", 32'h40000005, 32'h0C000123, 1'b0, 5'd0, 32'h0,
          mk(32'h40000005, 0, 0, 32'h123, 5'd4, 5'd31, 4'd12, 0, 1, 0, 0, 0));
    chk_j("jal_target", 1'b1, 32'h40000123, 1'b1);
    drive("ori_zext", 32'h20, 32'h34048000, 1'b0, 5'd0, 32'h0,
          mk(32'h20, 0, 32'h55, 32'h00008000, 0, 4, 4'd3, 1, 1, 0, 0, 0));
    drive("addi_sext", 32'h21, 32'h20048000, 1'b0, 5'd0, 32'h0,
          mk(32'h21, 0, 32'h55, 32'hFFFF8000, 0, 4, 4'd0, 1, 1, 0, 0, 0));
    drive("illegal_op", 32'h22, 32'hFC221234, 1'b0, 5'd0, 32'h0,
          mk(32'h22, 7, 7, 32'h1234, 5'd8, 0, 4'd0, 0, 0, 0, 0, 1));
    chk_j("illegal_no_jump", 1'b0, 32'h0, 1'b0);
    drive("wr_r0_bypass", 32'h23, 32'h00003020, 1'b1, 5'd0, 32'hFFFF,
          mk(32'h23, 0, 0, 32'h3020, 0, 6, 4'd0, 0, 1, 0, 0, 0));
    drive("r0_later", 32'h24, 32'h00013825, 1'b0, 5'd0, 32'h0,
          mk(32'h24, 0, 7, 32'h3825, 0, 7, 4'd3, 0, 1, 0, 0, 0));
    drive("jr", 32'h25, 32'h00A00008, 1'b0, 5'd0, 32'h0,
          mk(32'h25, 32'h1234, 0, 32'h8, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    chk_j("jr_target", 1'b1, 32'h1234, 1'b1);
    drive("jalr", 32'h30, 32'h00203809, 1'b0, 5'd0, 32'h0,
          mk(32'h30, 7, 0, 32'h3809, 0, 7, 4'd12, 0, 1, 0, 0, 0));
    chk_j("jalr_target", 1'b1, 32'h7, 1'b1);
    drive("illegal_funct", 32'h31, 32'h0000003F, 1'b0, 5'd0, 32'h0,
          mk(32'h31, 0, 0, 32'h3F, 0, 0, 4'd0, 0, 0, 0, 0, 1));
    drive("lw", 32'h32, 32'h8C220004, 1'b0, 5'd0, 32'h0,
          mk(32'h32, 7, 7, 32'h4, 0, 2, 4'd0, 1, 1, 1, 0, 0));
    drive("sw", 32'h33, 32'hAC220008, 1'b0, 5'd0, 32'h0,
          mk(32'h33, 7, 7, 32'h8, 0, 0, 4'd0, 1, 0, 0, 1, 0));
    drive("sra", 32'h34, 32'h00011943, 1'b0, 5'd0, 32'h0,
          mk(32'h34, 0, 7, 32'h1943, 5'd5, 3, 4'd10, 0, 1, 0, 0, 0));

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d bundles never checked, want 0", q.size());
    end

    rst = 1'b0;
    #1;
    n_vec++;
    if (act() !== z) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", act(), z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
